// File: rtl/gsensor_access_sequencer.sv
// gsensor_access_sequencer
// Sequences every register access to the DE0-Nano accelerometer: plays the
// fixed configuration table once after reset (or on re-init / timeout), then
// polls DATAX0/DATAX1 every POLL_DIV cycles and publishes a 10-bit X sample.
// All SPI command outputs are registered, so GO appears one cycle after the
// FSM sits in an ISSUE state; that GO cycle is the first cycle of the WAIT.
module gsensor_access_sequencer #(
    parameter int POLL_DIV = 800000,
    parameter int TIMEOUT  = 4096
) (
    input  logic       iRSTN,
    input  logic       iCLK,
    input  logic       iREINIT,
    output logic       oSPI_GO,
    output logic       oSPI_RW,
    output logic [5:0] oSPI_ADDR,
    output logic [7:0] oSPI_WDATA,
    input  logic       iSPI_DONE,
    input  logic [7:0] iSPI_RDATA,
    output logic [9:0] oDIG,
    output logic       oDIG_VALID,
    output logic       oCFG_DONE,
    output logic       oERR
);

    localparam logic [23:0] PCNT_LAST = 24'(POLL_DIV - 1);
    localparam logic [15:0] WCNT_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  TBL_LAST  = 4'd10;
    localparam logic [5:0]  ADDR_X0   = 6'h32;
    localparam logic [5:0]  ADDR_X1   = 6'h33;

    typedef enum logic [2:0] {
        INIT_ISSUE,
        INIT_WAIT,
        POLL_WAIT,
        RD_LO_ISSUE,
        RD_LO_WAIT,
        RD_HI_ISSUE,
        RD_HI_WAIT
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_idx,   w_idx_nxt;
    logic [23:0] r_pcnt,  w_pcnt_nxt;
    logic [15:0] r_wcnt,  w_wcnt_nxt;
    logic        r_pend,  w_pend_nxt;
    logic [7:0]  r_lo,    w_lo_nxt;
    logic        r_go,    w_go_nxt;
    logic        r_rw,    w_rw_nxt;
    logic [5:0]  r_addr,  w_addr_nxt;
    logic [7:0]  r_wdata, w_wdata_nxt;
    logic [9:0]  r_dig,   w_dig_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_cfg,   w_cfg_nxt;
    logic        r_err,   w_err_nxt;

    logic [5:0]  w_tbl_addr;
    logic [7:0]  w_tbl_data;
    logic        w_done_ok;
    logic        w_wait_expired;
    logic        w_timeout;

    // A DONE coinciding with our own GO cannot belong to this command.
    assign w_done_ok      = iSPI_DONE & ~r_go;
    assign w_wait_expired = (r_wcnt == WCNT_LAST);

    assign oSPI_GO    = r_go;
    assign oSPI_RW    = r_rw;
    assign oSPI_ADDR  = r_addr;
    assign oSPI_WDATA = r_wdata;
    assign oDIG       = r_dig;
    assign oDIG_VALID = r_valid;
    assign oCFG_DONE  = r_cfg;
    assign oERR       = r_err;

    // Configuration ROM; POWER_CTL goes last so measurement starts fully set up.
    always_comb begin
        w_tbl_addr = 6'h00;
        w_tbl_data = 8'h00;
        case (r_idx)
            4'd0:    begin w_tbl_addr = 6'h24; w_tbl_data = 8'h20; end
            4'd1:    begin w_tbl_addr = 6'h25; w_tbl_data = 8'h03; end
            4'd2:    begin w_tbl_addr = 6'h26; w_tbl_data = 8'h01; end
            4'd3:    begin w_tbl_addr = 6'h27; w_tbl_data = 8'h7F; end
            4'd4:    begin w_tbl_addr = 6'h28; w_tbl_data = 8'h09; end
            4'd5:    begin w_tbl_addr = 6'h29; w_tbl_data = 8'h46; end
            4'd6:    begin w_tbl_addr = 6'h2C; w_tbl_data = 8'h09; end
            4'd7:    begin w_tbl_addr = 6'h2E; w_tbl_data = 8'h10; end
            4'd8:    begin w_tbl_addr = 6'h2F; w_tbl_data = 8'h10; end
            4'd9:    begin w_tbl_addr = 6'h31; w_tbl_data = 8'h40; end
            4'd10:   begin w_tbl_addr = 6'h2D; w_tbl_data = 8'h08; end
            default: begin w_tbl_addr = 6'h00; w_tbl_data = 8'h00; end
        endcase
    end

    // Next-state and next-output logic for the whole sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_pcnt_nxt  = r_pcnt;
        w_wcnt_nxt  = r_wcnt;
        w_pend_nxt  = r_pend | iREINIT;
        w_lo_nxt    = r_lo;
        w_go_nxt    = 1'b0;
        w_rw_nxt    = r_rw;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_dig_nxt   = r_dig;
        w_valid_nxt = 1'b0;
        w_cfg_nxt   = r_cfg;
        w_err_nxt   = r_err;
        w_timeout   = 1'b0;

        case (r_state)
            INIT_ISSUE: begin
                w_go_nxt    = 1'b1;
                w_rw_nxt    = 1'b0;
                w_addr_nxt  = w_tbl_addr;
                w_wdata_nxt = w_tbl_data;
                w_wcnt_nxt  = '0;
                w_state_nxt = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (w_done_ok) begin
                    if (r_idx == TBL_LAST) begin
                        // A re-init request seen during the table is satisfied by it.
                        w_cfg_nxt   = 1'b1;
                        w_pcnt_nxt  = '0;
                        w_pend_nxt  = iREINIT;
                        w_state_nxt = POLL_WAIT;
                    end else begin
                        w_idx_nxt   = r_idx + 4'd1;
                        w_state_nxt = INIT_ISSUE;
                    end
                end else if (w_wait_expired) begin
                    w_timeout = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt + 16'd1;
                end
            end
            POLL_WAIT: begin
                if (r_pcnt == PCNT_LAST) begin
                    w_pcnt_nxt = '0;
                    if (r_pend) begin
                        w_idx_nxt   = '0;
                        w_cfg_nxt   = 1'b0;
                        w_pend_nxt  = iREINIT;
                        w_state_nxt = INIT_ISSUE;
                    end else begin
                        w_state_nxt = RD_LO_ISSUE;
                    end
                end else begin
                    w_pcnt_nxt = r_pcnt + 24'd1;
                end
            end
            RD_LO_ISSUE: begin
                w_go_nxt    = 1'b1;
                w_rw_nxt    = 1'b1;
                w_addr_nxt  = ADDR_X0;
                w_wcnt_nxt  = '0;
                w_state_nxt = RD_LO_WAIT;
            end
            RD_LO_WAIT: begin
                if (w_done_ok) begin
                    w_lo_nxt    = iSPI_RDATA;
                    w_state_nxt = RD_HI_ISSUE;
                end else if (w_wait_expired) begin
                    w_timeout = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt + 16'd1;
                end
            end
            RD_HI_ISSUE: begin
                w_go_nxt    = 1'b1;
                w_rw_nxt    = 1'b1;
                w_addr_nxt  = ADDR_X1;
                w_wcnt_nxt  = '0;
                w_state_nxt = RD_HI_WAIT;
            end
            RD_HI_WAIT: begin
                if (w_done_ok) begin
                    w_dig_nxt   = {iSPI_RDATA[1:0], r_lo};
                    w_valid_nxt = 1'b1;
                    w_pcnt_nxt  = '0;
                    w_state_nxt = POLL_WAIT;
                end else if (w_wait_expired) begin
                    w_timeout = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt + 16'd1;
                end
            end
            default: begin
                w_idx_nxt   = '0;
                w_state_nxt = INIT_ISSUE;
            end
        endcase

        // A silent engine forces a full replay; the last sample stays published.
        if (w_timeout) begin
            w_err_nxt   = 1'b1;
            w_cfg_nxt   = 1'b0;
            w_idx_nxt   = '0;
            w_state_nxt = INIT_ISSUE;
        end
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            r_state <= INIT_ISSUE;
            r_idx   <= '0;
            r_pcnt  <= '0;
            r_wcnt  <= '0;
            r_pend  <= 1'b0;
            r_lo    <= '0;
            r_go    <= 1'b0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_dig   <= '0;
            r_valid <= 1'b0;
            r_cfg   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_pend  <= w_pend_nxt;
            r_lo    <= w_lo_nxt;
            r_go    <= w_go_nxt;
            r_rw    <= w_rw_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_dig   <= w_dig_nxt;
            r_valid <= w_valid_nxt;
            r_cfg   <= w_cfg_nxt;
            r_err   <= w_err_nxt;
        end
    end

endmodule
